// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl shared types: opcode/mem-op codes, FSM states.
// Bus widths and the load-code helper used by the sequencer.
package pipe_ctrl_pkg;

   localparam int INSTR_W   = 32;
   localparam int MEM_OP_W  = 4;
   localparam int REG_IDX_W = 5;
   localparam int WORD_W    = 32;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;

   localparam logic [MEM_OP_W-1:0] MEM_NONE = 4'd0;
   localparam logic [MEM_OP_W-1:0] MEM_LB   = 4'd1;
   localparam logic [MEM_OP_W-1:0] MEM_LH   = 4'd2;
   localparam logic [MEM_OP_W-1:0] MEM_LW   = 4'd3;
   localparam logic [MEM_OP_W-1:0] MEM_LBU  = 4'd4;
   localparam logic [MEM_OP_W-1:0] MEM_LHU  = 4'd5;
   localparam logic [MEM_OP_W-1:0] MEM_SB   = 4'd6;
   localparam logic [MEM_OP_W-1:0] MEM_SH   = 4'd7;
   localparam logic [MEM_OP_W-1:0] MEM_SW   = 4'd8;

   localparam int PIPE_ST_W = 2;

   typedef enum logic [PIPE_ST_W-1:0] {
      PIPE_ST_HOLD  = 2'd0,
      PIPE_ST_RUN   = 2'd1,
      PIPE_ST_FLUSH = 2'd2
   } pipe_st_e;

   function automatic logic is_load(
      input logic [MEM_OP_W-1:0] op
   );
      return op inside {MEM_LB, MEM_LH, MEM_LW,
                        MEM_LBU, MEM_LHU};
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl bus: pipeline hazard inputs and stage controls.
// Stats counters exist only with PIPE_CTRL_STATS_EN.
interface pipe_ctrl_if;
   import pipe_ctrl_pkg::*;

   logic [INSTR_W-1:0]   i_id_instr;
   logic [MEM_OP_W-1:0]  i_ex_mem_op;
   logic [REG_IDX_W-1:0] i_ex_dest_reg;
   logic                 i_ex_redirect;
   logic                 i_mem_busy;
   logic                 o_if_stall;
   logic                 o_id_stall;
   logic                 o_id_clr;
   logic                 o_ex_clr;
   logic                 o_ex_stall;
   logic                 o_rf_aresetn;
`ifdef PIPE_CTRL_STATS_EN
   logic [WORD_W-1:0]    o_stall_cnt;
   logic [WORD_W-1:0]    o_flush_cnt;

   modport master (
      input  i_id_instr, i_ex_mem_op, i_ex_dest_reg,
      input  i_ex_redirect, i_mem_busy,
      output o_if_stall, o_id_stall, o_id_clr,
      output o_ex_clr, o_ex_stall, o_rf_aresetn,
      output o_stall_cnt, o_flush_cnt
   );
   modport slave (
      output i_id_instr, i_ex_mem_op, i_ex_dest_reg,
      output i_ex_redirect, i_mem_busy,
      input  o_if_stall, o_id_stall, o_id_clr,
      input  o_ex_clr, o_ex_stall, o_rf_aresetn,
      input  o_stall_cnt, o_flush_cnt
   );
`else
   modport master (
      input  i_id_instr, i_ex_mem_op, i_ex_dest_reg,
      input  i_ex_redirect, i_mem_busy,
      output o_if_stall, o_id_stall, o_id_clr,
      output o_ex_clr, o_ex_stall, o_rf_aresetn
   );
   modport slave (
      output i_id_instr, i_ex_mem_op, i_ex_dest_reg,
      output i_ex_redirect, i_mem_busy,
      input  o_if_stall, o_id_stall, o_id_clr,
      input  o_ex_clr, o_ex_stall, o_rf_aresetn
   );
`endif

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use detector: decodes rs1/rs2 usage of the ID
// instruction and matches it against a load in EX.
module pipe_ctrl_hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [INSTR_W-1:0]   instr_i,
   input  logic [MEM_OP_W-1:0]  mem_op_i,
   input  logic [REG_IDX_W-1:0] dest_i,
   output logic                 load_use_o
);

   logic [6:0]           opc;
   logic [REG_IDX_W-1:0] rs1;
   logic [REG_IDX_W-1:0] rs2;
   logic                 use_rs1;
   logic                 use_rs2;
   logic                 unused_bits;

   assign opc = instr_i[6:0];
   assign rs1 = instr_i[19:15];
   assign rs2 = instr_i[24:20];
   assign unused_bits = ^{instr_i[31:25], instr_i[14:7]};

   // source-register usage by opcode class
   always_comb begin
      use_rs1 = 1'b1;
      use_rs2 = 1'b0;
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL: use_rs1 = 1'b0;
         OPC_OP, OPC_STORE, OPC_BRANCH: use_rs2 = 1'b1;
         default: ;
      endcase
   end

   // x0 is never a real dependency
   assign load_use_o = is_load(mem_op_i)
                     && (dest_i != '0)
                     && ((use_rs1 && rs1 == dest_i)
                      || (use_rs2 && rs2 == dest_i));

endmodule

// File: rtl/pipe_ctrl.sv
// Front-end pipeline sequencer: bring-up, interlock, freeze, flush.
// Optional stats counters enabled by define PIPE_CTRL_STATS_EN.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int RESET_CYCLES = 5,
   parameter int FLUSH_CYCLES = 1
) (
   input logic         clk,
   input logic         aresetn,
   pipe_ctrl_if.master bus
);

   localparam int CNT_MAX = (RESET_CYCLES > FLUSH_CYCLES)
                          ? RESET_CYCLES : FLUSH_CYCLES;
   localparam int CNT_W = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] FL_LAST  = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   pipe_st_e         state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic             rf_q, rf_d;
   logic             load_use;
   logic             redir;
   logic             busy;
   logic             if_stall, id_stall, id_clr;
   logic             ex_clr, ex_stall;

   assign busy  = bus.i_mem_busy;
   assign redir = bus.i_ex_redirect | pend_q;

   pipe_ctrl_hazard_detect u_hazard_detect (
      .instr_i    (bus.i_id_instr),
      .mem_op_i   (bus.i_ex_mem_op),
      .dest_i     (bus.i_ex_dest_reg),
      .load_use_o (load_use)
   );

   // state, counter, pending redirect and rf reset registers
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= PIPE_ST_HOLD;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         rf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         rf_q    <= rf_d;
      end
   end

   // next state; a busy cycle defers any redirect into pend
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      rf_d    = rf_q;
      unique case (state_q)
         PIPE_ST_HOLD: begin
            pend_d = 1'b0;
            if (cnt_q == RST_LAST) begin
               state_d = PIPE_ST_RUN;
               cnt_d   = '0;
               rf_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         PIPE_ST_RUN: begin
            if (busy) begin
               pend_d = pend_q | bus.i_ex_redirect;
            end else if (redir) begin
               pend_d = 1'b0;
               if (FLUSH_CYCLES > 1) begin
                  state_d = PIPE_ST_FLUSH;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         PIPE_ST_FLUSH: begin
            if (busy) begin
               pend_d = pend_q | bus.i_ex_redirect;
            end else if (redir) begin
               pend_d = 1'b0;
               cnt_d  = CNT_ONE;
            end else if (cnt_q == FL_LAST) begin
               state_d = PIPE_ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = PIPE_ST_HOLD;
      endcase
   end

   // stage controls; clr and id_stall are never both set
   always_comb begin
      if_stall = 1'b0;
      id_stall = 1'b0;
      id_clr   = 1'b0;
      ex_clr   = 1'b0;
      ex_stall = 1'b0;
      unique case (state_q)
         PIPE_ST_HOLD: begin
            if_stall = 1'b1;
            id_clr   = 1'b1;
            ex_clr   = 1'b1;
         end
         PIPE_ST_RUN: begin
            if (busy) begin
               if_stall = 1'b1;
               id_stall = 1'b1;
               ex_stall = 1'b1;
            end else if (redir) begin
               id_clr = 1'b1;
               ex_clr = 1'b1;
            end else if (load_use) begin
               if_stall = 1'b1;
               id_stall = 1'b1;
               ex_clr   = 1'b1;
            end
         end
         PIPE_ST_FLUSH: begin
            id_clr = 1'b1;
            ex_clr = 1'b1;
            if (busy) begin
               if_stall = 1'b1;
               ex_stall = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign bus.o_if_stall   = if_stall;
   assign bus.o_id_stall   = id_stall;
   assign bus.o_id_clr     = id_clr;
   assign bus.o_ex_clr     = ex_clr;
   assign bus.o_ex_stall   = ex_stall;
   assign bus.o_rf_aresetn = rf_q;

`ifdef PIPE_CTRL_STATS_EN
   logic [WORD_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [WORD_W-1:0] flush_cnt_q, flush_cnt_d;
   logic              lu_fire;
   logic              fl_fire;

   assign lu_fire = (state_q == PIPE_ST_RUN) && !busy
                 && !redir && load_use;
   assign fl_fire = (state_q != PIPE_ST_HOLD) && id_clr;

   // saturating event counters
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (lu_fire && stall_cnt_q != '1)
         stall_cnt_d = stall_cnt_q + 1'b1;
      if (fl_fire && flush_cnt_q != '1)
         flush_cnt_d = flush_cnt_q + 1'b1;
   end

   // counter registers
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.o_stall_cnt = stall_cnt_q;
   assign bus.o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: instances with FLUSH_CYCLES 1 and 3
// checked against a cycle-level behavioural model.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int RC = 5;
   localparam logic [31:0] NOP = 32'h0000_0013;
   // ADD x1,x5,x2 / LUI x3 with bits[19:15]=5 / ADD x1,x0,x0
   localparam logic [31:0] ADD15 = {7'd0, 5'd2, 5'd5, 3'd0, 5'd1, OPC_OP};
   localparam logic [31:0] LUI5 = {12'd0, 5'd5, 3'd0, 5'd3, OPC_LUI};
   localparam logic [31:0] ADD00 = {7'd0, 5'd0, 5'd0, 3'd0, 5'd1, OPC_OP};
   localparam logic [31:0] SW5 = {7'd0, 5'd5, 5'd1, 3'd2, 5'd0, OPC_STORE};

   logic                 clk = 1'b0;
   logic                 aresetn = 1'b0;
   logic [INSTR_W-1:0]   instr = NOP;
   logic [MEM_OP_W-1:0]  mop = MEM_NONE;
   logic [REG_IDX_W-1:0] dst = '0;
   logic                 redir = 1'b0;
   logic                 busy = 1'b0;
   int                   errors = 0;
   int                   checks = 0;

   always #5 clk = ~clk;

   pipe_ctrl_if ifa ();
   pipe_ctrl_if ifb ();

   assign ifa.i_id_instr    = instr;
   assign ifa.i_ex_mem_op   = mop;
   assign ifa.i_ex_dest_reg = dst;
   assign ifa.i_ex_redirect = redir;
   assign ifa.i_mem_busy    = busy;
   assign ifb.i_id_instr    = instr;
   assign ifb.i_ex_mem_op   = mop;
   assign ifb.i_ex_dest_reg = dst;
   assign ifb.i_ex_redirect = redir;
   assign ifb.i_mem_busy    = busy;

   pipe_ctrl #(.RESET_CYCLES(RC), .FLUSH_CYCLES(1)) dut_a (
      .clk(clk), .aresetn(aresetn), .bus(ifa.master)
   );
   pipe_ctrl #(.RESET_CYCLES(RC), .FLUSH_CYCLES(3)) dut_b (
      .clk(clk), .aresetn(aresetn), .bus(ifb.master)
   );

   // model state: remaining bring-up / extra flush cycles
   int         fc [2] = '{1, 3};
   int         hold_left [2];
   int         flush_left [2];
   bit         pend [2];
   int         m_stall [2];
   int         m_flush [2];
   logic [5:0] expv [2];

   // {if_stall,id_stall,id_clr,ex_clr,ex_stall,rf_aresetn}
   function automatic logic [5:0] obs(input int k);
      if (k == 0)
         return {ifa.o_if_stall, ifa.o_id_stall, ifa.o_id_clr,
                 ifa.o_ex_clr, ifa.o_ex_stall, ifa.o_rf_aresetn};
      return {ifb.o_if_stall, ifb.o_id_stall, ifb.o_id_clr,
              ifb.o_ex_clr, ifb.o_ex_stall, ifb.o_rf_aresetn};
   endfunction

   function automatic bit ref_lu(input logic [31:0] ins,
                                 input logic [3:0] op,
                                 input logic [4:0] rd);
      logic [6:0] opc;
      bit r1, r2;
      opc = ins[6:0];
      r1 = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
      r2 = (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
      if (op < MEM_LB || op > MEM_LHU) return 1'b0;
      if (rd == 5'd0) return 1'b0;
      return (r1 && ins[19:15] == rd) || (r2 && ins[24:20] == rd);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         hold_left[k] = RC;
         flush_left[k] = 0;
         pend[k] = 1'b0;
         m_stall[k] = 0;
         m_flush[k] = 0;
      end
   endtask

   // drive one cycle of inputs and predict both DUTs
   task automatic step(input logic [31:0] ins, input logic [3:0] op,
                       input logic [4:0] rd, input logic rr,
                       input logic bz);
      bit lu, rq;
      logic [5:0] e;
      @(negedge clk);
      instr = ins; mop = op; dst = rd; redir = rr; busy = bz;
      #1;
      lu = ref_lu(ins, op, rd);
      for (int k = 0; k < 2; k++) begin
         rq = rr | pend[k];
         e = 6'b000001;
         if (hold_left[k] > 0) begin
            e = 6'b101100;
            hold_left[k]--;
         end else if (flush_left[k] > 0) begin
            e = bz ? 6'b101111 : 6'b001101;
            m_flush[k]++;
            if (bz) pend[k] = pend[k] | rr;
            else if (rq) begin
               flush_left[k] = fc[k] - 1;
               pend[k] = 1'b0;
            end else flush_left[k]--;
         end else if (bz) begin
            e = 6'b110011;
            pend[k] = pend[k] | rr;
         end else if (rq) begin
            e = 6'b001101;
            pend[k] = 1'b0;
            flush_left[k] = fc[k] - 1;
            m_flush[k]++;
         end else if (lu) begin
            e = 6'b110101;
            m_stall[k]++;
         end
         expv[k] = e;
      end
   endtask

   task automatic bring_up(input string nm);
      @(posedge clk);
      #1 aresetn = 1'b1;
      for (int c = 0; c <= RC; c++) begin
         step(NOP, MEM_NONE, 5'd0, 1'b0, 1'b0);
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv[k]) begin
               errors++;
               $display("FAIL %s dut%0d cyc%0d: got %b want %b",
                        nm, k, c, obs(k), expv[k]);
            end
         end
      end
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      model_reset();
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs(k) !== 6'b101100) begin
            errors++;
            $display("FAIL reset_state dut%0d: got %b want %b",
                     k, obs(k), 6'b101100);
         end
      end
      bring_up("bring_up");
   endtask

   task automatic test_load_use();
      logic [31:0] ins [6] = '{ADD15, ADD15, LUI5, ADD00, SW5, NOP};
      logic [3:0]  op [6] = '{MEM_LW, MEM_NONE, MEM_LW, MEM_LW,
                              MEM_LH, MEM_NONE};
      logic [4:0]  rd [6] = '{5'd5, 5'd0, 5'd5, 5'd0, 5'd5, 5'd0};
      logic [5:0]  want [6] = '{6'b110101, 6'b000001, 6'b000001,
                                6'b000001, 6'b110101, 6'b000001};
      for (int i = 0; i < 6; i++) begin
         step(ins[i], op[i], rd[i], 1'b0, 1'b0);
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== want[i]) begin
               errors++;
               $display("FAIL load_use dut%0d step%0d: got %b want %b",
                        k, i, obs(k), want[i]);
            end
         end
      end
   endtask

   task automatic test_redirect();
      logic [5:0] wa [4] = '{6'b001101, 6'b000001,
                             6'b000001, 6'b000001};
      logic [5:0] wb [4] = '{6'b001101, 6'b001101,
                             6'b001101, 6'b000001};
      for (int i = 0; i < 4; i++) begin
         step(NOP, MEM_NONE, 5'd0, i == 0, 1'b0);
         checks++;
         if (obs(0) !== wa[i]) begin
            errors++;
            $display("FAIL redirect_f1 step%0d: got %b want %b",
                     i, obs(0), wa[i]);
         end
         checks++;
         if (obs(1) !== wb[i]) begin
            errors++;
            $display("FAIL redirect_f3 step%0d: got %b want %b",
                     i, obs(1), wb[i]);
         end
      end
   endtask

   task automatic test_busy_redirect();
      logic [5:0] wa [8] = '{6'b110011, 6'b110011, 6'b110011,
                             6'b110011, 6'b001101, 6'b000001,
                             6'b000001, 6'b000001};
      logic [5:0] wb [8] = '{6'b110011, 6'b110011, 6'b110011,
                             6'b110011, 6'b001101, 6'b001101,
                             6'b001101, 6'b000001};
      for (int i = 0; i < 8; i++) begin
         step(NOP, MEM_NONE, 5'd0, i == 0, i < 4);
         checks++;
         if (obs(0) !== wa[i]) begin
            errors++;
            $display("FAIL busy_redir_f1 step%0d: got %b want %b",
                     i, obs(0), wa[i]);
         end
         checks++;
         if (obs(1) !== wb[i]) begin
            errors++;
            $display("FAIL busy_redir_f3 step%0d: got %b want %b",
                     i, obs(1), wb[i]);
         end
      end
   endtask

   task automatic test_lu_and_redirect();
      step(ADD15, MEM_LW, 5'd5, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs(k) !== 6'b001101) begin
            errors++;
            $display("FAIL lu_redir dut%0d: got %b want %b",
                     k, obs(k), 6'b001101);
         end
      end
      for (int i = 0; i < 3; i++)
         step(NOP, MEM_NONE, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_in_flush();
      step(NOP, MEM_NONE, 5'd0, 1'b1, 1'b0);
      step(NOP, MEM_NONE, 5'd0, 1'b0, 1'b0);
      aresetn = 1'b0;
      model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs(k) !== 6'b101100) begin
            errors++;
            $display("FAIL midrun_reset dut%0d: got %b want %b",
                     k, obs(k), 6'b101100);
         end
      end
      bring_up("rebring_up");
   endtask

   task automatic test_random();
      logic [6:0] opcs [8] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP,
                               OPC_STORE, OPC_BRANCH, OPC_OP_IMM,
                               OPC_LOAD};
      logic [31:0] ins;
      for (int c = 0; c < 400; c++) begin
         ins = {7'($urandom), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 3'($urandom),
                5'($urandom), opcs[$urandom_range(0, 7)]};
         step(ins, 4'($urandom_range(0, 8)),
              5'($urandom_range(0, 7)),
              $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) == 0);
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv[k]) begin
               errors++;
               $display("FAIL random dut%0d cyc%0d: got %b want %b",
                        k, c, obs(k), expv[k]);
            end
         end
      end
   endtask

`ifdef PIPE_CTRL_STATS_EN
   task automatic test_stats();
      aresetn = 1'b0;
      model_reset();
      #1;
      checks++;
      if (ifa.o_stall_cnt !== '0 || ifa.o_flush_cnt !== '0) begin
         errors++;
         $display("FAIL stats_reset: got %0d/%0d want 0/0",
                  ifa.o_stall_cnt, ifa.o_flush_cnt);
      end
      bring_up("stats_bring_up");
      step(ADD15, MEM_LW, 5'd5, 1'b0, 1'b0);
      step(NOP, MEM_NONE, 5'd0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++)
         step(NOP, MEM_NONE, 5'd0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ((k == 0 ? ifa.o_stall_cnt : ifb.o_stall_cnt)
             !== 32'(m_stall[k])) begin
            errors++;
            $display("FAIL stall_cnt dut%0d: got %0d want %0d", k,
                     k == 0 ? ifa.o_stall_cnt : ifb.o_stall_cnt,
                     m_stall[k]);
         end
         checks++;
         if ((k == 0 ? ifa.o_flush_cnt : ifb.o_flush_cnt)
             !== 32'(m_flush[k])) begin
            errors++;
            $display("FAIL flush_cnt dut%0d: got %0d want %0d", k,
                     k == 0 ? ifa.o_flush_cnt : ifb.o_flush_cnt,
                     m_flush[k]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_load_use();
      test_redirect();
      test_busy_redirect();
      test_lu_and_redirect();
      test_reset_in_flush();
      test_random();
`ifdef PIPE_CTRL_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
